// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and control unit for the 3-stage MINI-RISC pipeline: stalls, flushes,
// PC redirect, E-stage forwarding selects, halt/resume and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int RA_W           = 3,
  parameter int LOAD_STALL_CYC = 1,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  rs1_D,
  input  logic [RA_W-1:0]  rs2_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic             halt_D,
  input  logic [RA_W-1:0]  rd_E,
  input  logic             mem_read_E,
  input  logic [1:0]       write_mode_E,
  input  logic [RA_W-1:0]  rs1_E,
  input  logic [RA_W-1:0]  rs2_E,
  input  logic             branch_taken_E,
  input  logic [10:0]      branch_addr_E,
  input  logic [RA_W-1:0]  rd_W,
  input  logic [1:0]       write_mode_W,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             stall_F,
  output logic             flush_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             redirect_valid,
  output logic [10:0]      redirect_pc,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_REDIR  = 2'd1;
  localparam logic [1:0] S_LSTALL = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam int MAXC = (LOAD_STALL_CYC > BRANCH_PENALTY) ? LOAD_STALL_CYC : BRANCH_PENALTY;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]    LS_INIT = CW'(LOAD_STALL_CYC - 1);
  localparam logic [CW-1:0]    BR_INIT = CW'(BRANCH_PENALTY - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [RA_W-1:0]  RA_ONE  = RA_W'(1);
  localparam logic [CNT_W-1:0] PC_ONE  = CNT_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, redirect_cnt_reg;

  logic            stall_f_c, flush_f_c, flush_d_c, redir_c, take_branch;
  logic            load_use;
  logic [RA_W-1:0] rd_w_plus1;
  logic [1:0]      fwd_a_c, fwd_b_c;

  assign load_use = mem_read_E && (write_mode_E != 2'b00) &&
                    ((use_rs1_D && rs1_D == rd_E) || (use_rs2_D && rs2_D == rd_E));

  // Paired writes land in rd and rd+1, wrapping at the top of the register file.
  assign rd_w_plus1 = rd_W + RA_ONE;

  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (write_mode_W != 2'b00 && rs1_E == rd_W)
      fwd_a_c = 2'b01;
    else if (write_mode_W == 2'b10 && rs1_E == rd_w_plus1)
      fwd_a_c = 2'b10;
    if (write_mode_W != 2'b00 && rs2_E == rd_W)
      fwd_b_c = 2'b01;
    else if (write_mode_W == 2'b10 && rs2_E == rd_w_plus1)
      fwd_b_c = 2'b10;
  end

  always_comb begin
    stall_f_c   = 1'b0;
    flush_f_c   = 1'b0;
    flush_d_c   = 1'b0;
    redir_c     = 1'b0;
    take_branch = 1'b0;
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      S_RUN: begin
        if (branch_taken_E) begin
          take_branch = 1'b1;
        end else if (load_use) begin
          stall_f_c = 1'b1;
          flush_d_c = 1'b1;
          if (LOAD_STALL_CYC > 1) begin
            state_next = S_LSTALL;
            cnt_next   = LS_INIT;
          end
        end else if (halt_D) begin
          stall_f_c  = 1'b1;
          flush_d_c  = 1'b1;
          state_next = S_HALT;
        end
      end
      S_REDIR: begin
        flush_f_c = 1'b1;
        flush_d_c = 1'b1;
        cnt_next  = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) state_next = S_RUN;
      end
      S_LSTALL: begin
        // E holds a bubble here, so a branch resolving now comes from an older slot.
        if (branch_taken_E) begin
          take_branch = 1'b1;
        end else begin
          stall_f_c = 1'b1;
          flush_d_c = 1'b1;
          cnt_next  = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) state_next = S_RUN;
        end
      end
      default: begin
        flush_d_c = 1'b1;
        if (resume) state_next = S_RUN;
        else        stall_f_c  = 1'b1;
      end
    endcase

    if (take_branch) begin
      flush_f_c = 1'b1;
      flush_d_c = 1'b1;
      redir_c   = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_next = S_REDIR;
        cnt_next   = BR_INIT;
      end else begin
        state_next = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg    <= '0;
      redirect_cnt_reg <= '0;
    end else if (cnt_clr) begin
      stall_cnt_reg    <= '0;
      redirect_cnt_reg <= '0;
    end else begin
      if (stall_f_c && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + PC_ONE;
      if (redir_c && redirect_cnt_reg != '1)
        redirect_cnt_reg <= redirect_cnt_reg + PC_ONE;
    end
  end

  // Every output is forced quiet while reset is held.
  assign stall_F        = !reset && stall_f_c;
  assign flush_F        = !reset && flush_f_c;
  assign stall_D        = 1'b0;
  assign flush_D        = !reset && flush_d_c;
  assign redirect_valid = !reset && redir_c;
  assign redirect_pc    = (!reset && redir_c) ? branch_addr_E : 11'd0;
  assign fwd_a_sel      = reset ? 2'b00 : fwd_a_c;
  assign fwd_b_sel      = reset ? 2'b00 : fwd_b_c;
  assign halted         = !reset && (state_reg == S_HALT);
  assign stall_cnt      = stall_cnt_reg;
  assign redirect_cnt   = redirect_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for single-cycle control
// and forwarding, plus sequences for load-use, branch penalty, halt and counter saturation.
module tb_pipeline_hazard_ctrl;

  localparam int RA_W = 3;
  localparam int LSC  = 3;
  localparam int BRP  = 2;
  localparam int CW   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [RA_W-1:0] rs1_D, rs2_D, rd_E, rs1_E, rs2_E, rd_W;
  logic            use_rs1_D, use_rs2_D, halt_D, mem_read_E, branch_taken_E, resume, cnt_clr;
  logic [1:0]      write_mode_E, write_mode_W;
  logic [10:0]     branch_addr_E;
  logic            stall_F, flush_F, stall_D, flush_D, redirect_valid, halted;
  logic [10:0]     redirect_pc;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic [CW-1:0]   stall_cnt, redirect_cnt;
  logic [19:0]     act_ctl;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.RA_W(RA_W), .LOAD_STALL_CYC(LSC), .BRANCH_PENALTY(BRP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .halt_D(halt_D),
    .rd_E(rd_E), .mem_read_E(mem_read_E), .write_mode_E(write_mode_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .branch_taken_E(branch_taken_E), .branch_addr_E(branch_addr_E),
    .rd_W(rd_W), .write_mode_W(write_mode_W), .resume(resume), .cnt_clr(cnt_clr),
    .stall_F(stall_F), .flush_F(flush_F), .stall_D(stall_D), .flush_D(flush_D),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  assign act_ctl = {stall_F, flush_F, stall_D, flush_D, redirect_valid, redirect_pc, fwd_a_sel, fwd_b_sel};

  typedef struct {
    logic [2:0]  rs1_D, rs2_D;
    logic        use1, use2, halt;
    logic [2:0]  rd_E;
    logic        mr;
    logic [1:0]  wm_E;
    logic [2:0]  rs1_E, rs2_E;
    logic        br;
    logic [10:0] ba;
    logic [2:0]  rd_W;
    logic [1:0]  wm_W;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [19:0] ctl(input logic sf, input logic ff, input logic fd, input logic rv,
                                      input logic [10:0] pc, input logic [1:0] fa, input logic [1:0] fb);
    return {sf, ff, 1'b0, fd, rv, pc, fa, fb};
  endfunction

  function automatic vec_t mkv(input logic [2:0] r1d, input logic [2:0] r2d, input logic u1,
                               input logic u2, input logic h, input logic [2:0] rde, input logic mr,
                               input logic [1:0] wme, input logic [2:0] r1e, input logic [2:0] r2e,
                               input logic br, input logic [10:0] ba, input logic [2:0] rdw,
                               input logic [1:0] wmw, input logic [19:0] e);
    vec_t v;
    v.rs1_D = r1d; v.rs2_D = r2d; v.use1 = u1; v.use2 = u2; v.halt = h;
    v.rd_E = rde; v.mr = mr; v.wm_E = wme; v.rs1_E = r1e; v.rs2_E = r2e;
    v.br = br; v.ba = ba; v.rd_W = rdw; v.wm_W = wmw; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    rs1_D = 0; rs2_D = 0; use_rs1_D = 0; use_rs2_D = 0; halt_D = 0;
    rd_E = 0; mem_read_E = 0; write_mode_E = 0; rs1_E = 0; rs2_E = 0;
    branch_taken_E = 0; branch_addr_E = 0; rd_W = 0; write_mode_W = 0;
    resume = 0; cnt_clr = 0;
  endtask

  task automatic apply(input vec_t v);
    rs1_D = v.rs1_D; rs2_D = v.rs2_D; use_rs1_D = v.use1; use_rs2_D = v.use2; halt_D = v.halt;
    rd_E = v.rd_E; mem_read_E = v.mr; write_mode_E = v.wm_E; rs1_E = v.rs1_E; rs2_E = v.rs2_E;
    branch_taken_E = v.br; branch_addr_E = v.ba; rd_W = v.rd_W; write_mode_W = v.wm_W;
  endtask

  // Pulses the asynchronous reset in the low clock phase and leaves idle inputs applied.
  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic set_load_use();
    mem_read_E = 1; rd_E = 2; write_mode_E = 2'b01; rs2_D = 2; use_rs2_D = 1;
  endtask

  initial begin
    set_idle();
    tbl[0]  = mkv(0,0,0,0,0, 0,0,2'b00, 0,0, 0,11'h000, 0,2'b00, ctl(0,0,0,0,0,2'b00,2'b00));
    tbl[1]  = mkv(0,0,0,0,0, 0,0,2'b00, 3,4, 0,11'h000, 3,2'b01, ctl(0,0,0,0,0,2'b01,2'b00));
    tbl[2]  = mkv(0,0,0,0,0, 0,0,2'b00, 7,0, 0,11'h000, 7,2'b10, ctl(0,0,0,0,0,2'b01,2'b10));
    tbl[3]  = mkv(0,0,0,0,0, 0,0,2'b00, 7,0, 0,11'h000, 7,2'b00, ctl(0,0,0,0,0,2'b00,2'b00));
    tbl[4]  = mkv(0,0,0,0,0, 0,0,2'b00, 5,6, 0,11'h000, 5,2'b11, ctl(0,0,0,0,0,2'b01,2'b00));
    tbl[5]  = mkv(0,0,0,0,0, 0,0,2'b00, 3,3, 0,11'h000, 2,2'b10, ctl(0,0,0,0,0,2'b10,2'b10));
    tbl[6]  = mkv(0,2,0,1,0, 2,1,2'b01, 0,0, 0,11'h000, 0,2'b00, ctl(1,0,1,0,0,2'b00,2'b00));
    tbl[7]  = mkv(0,2,0,0,0, 2,1,2'b01, 0,0, 0,11'h000, 0,2'b00, ctl(0,0,0,0,0,2'b00,2'b00));
    tbl[8]  = mkv(0,2,0,1,0, 2,1,2'b00, 0,0, 0,11'h000, 0,2'b00, ctl(0,0,0,0,0,2'b00,2'b00));
    tbl[9]  = mkv(0,2,0,1,0, 2,0,2'b01, 0,0, 0,11'h000, 0,2'b00, ctl(0,0,0,0,0,2'b00,2'b00));
    tbl[10] = mkv(5,5,1,0,0, 5,1,2'b10, 0,0, 0,11'h000, 0,2'b00, ctl(1,0,1,0,0,2'b00,2'b00));
    tbl[11] = mkv(0,0,0,0,1, 0,0,2'b00, 0,0, 0,11'h000, 0,2'b00, ctl(1,0,1,0,0,2'b00,2'b00));
    tbl[12] = mkv(0,2,0,1,1, 2,1,2'b01, 1,0, 1,11'h123, 1,2'b01, ctl(0,1,1,1,11'h123,2'b01,2'b00));
    tbl[13] = mkv(0,0,0,0,0, 0,0,2'b00, 0,0, 1,11'h7FF, 0,2'b00, ctl(0,1,1,1,11'h7FF,2'b00,2'b00));
    tbl[14] = mkv(0,3,0,1,0, 2,1,2'b01, 0,0, 0,11'h000, 0,2'b00, ctl(0,0,0,0,0,2'b00,2'b00));

    // Outputs stay quiet while reset is high, even with active inputs.
    @(negedge clk);
    apply(tbl[12]);
    #1 chk("reset_quiet", {12'd0, act_ctl}, 32'd0);
    do_reset();
    #1;
    chk("reset_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    chk("reset_redir_cnt", {24'd0, redirect_cnt}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      do_reset();
      apply(tbl[i]);
      #1 chk($sformatf("vec%0d", i), {12'd0, act_ctl}, {12'd0, tbl[i].exp});
      $display("vec %0d: ctl=%05h exp=%05h", i, act_ctl, tbl[i].exp);
    end

    // Load-use: exactly LSC stall cycles, E holds a bubble after the first.
    do_reset();
    set_load_use();
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("lstall_c%0d", i), {12'd0, act_ctl},
             {12'd0, ctl(i < LSC, 0, i < LSC, 0, 0, 2'b00, 2'b00)});
      @(negedge clk);
      mem_read_E = 0;
    end
    #1 chk("lstall_cnt", {24'd0, stall_cnt}, LSC);
    $display("seq load_use: stall_cnt=%0d", stall_cnt);

    // Branch beats load-use and halt; one extra flush cycle with redirect held off.
    do_reset();
    set_load_use();
    halt_D = 1; branch_taken_E = 1; branch_addr_E = 11'h123;
    #1 chk("br_c0", {12'd0, act_ctl}, {12'd0, ctl(0,1,1,1,11'h123,2'b00,2'b00)});
    @(negedge clk);
    #1 chk("br_c1", {12'd0, act_ctl}, {12'd0, ctl(0,1,1,0,11'h000,2'b00,2'b00)});
    @(negedge clk);
    set_idle();
    #1 chk("br_c2", {12'd0, act_ctl}, 32'd0);
    chk("br_redir_cnt", {24'd0, redirect_cnt}, 32'd1);
    chk("br_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    $display("seq branch: redirect_cnt=%0d", redirect_cnt);

    // Branch resolving during a load-use stall is honoured.
    do_reset();
    set_load_use();
    #1 chk("lsbr_c0", {12'd0, act_ctl}, {12'd0, ctl(1,0,1,0,0,2'b00,2'b00)});
    @(negedge clk);
    mem_read_E = 0; branch_taken_E = 1; branch_addr_E = 11'h055;
    #1 chk("lsbr_c1", {12'd0, act_ctl}, {12'd0, ctl(0,1,1,1,11'h055,2'b00,2'b00)});
    @(negedge clk);
    branch_taken_E = 0;
    #1 chk("lsbr_c2", {12'd0, act_ctl}, {12'd0, ctl(0,1,1,0,0,2'b00,2'b00)});
    @(negedge clk);
    set_idle();
    #1 chk("lsbr_c3", {12'd0, act_ctl}, 32'd0);
    chk("lsbr_redir_cnt", {24'd0, redirect_cnt}, 32'd1);
    chk("lsbr_stall_cnt", {24'd0, stall_cnt}, 32'd1);
    $display("seq lstall+branch: redirect_cnt=%0d stall_cnt=%0d", redirect_cnt, stall_cnt);

    // Halt / resume, resume ignored while running, reset out of HALT.
    do_reset();
    resume = 1;
    #1 chk("resume_run", {12'd0, act_ctl}, 32'd0);
    @(negedge clk);
    resume = 0;
    #1 chk("resume_run_halted", {31'd0, halted}, 32'd0);
    halt_D = 1;
    #1 chk("halt_c0", {12'd0, act_ctl}, {12'd0, ctl(1,0,1,0,0,2'b00,2'b00)});
    @(negedge clk);
    for (int i = 1; i < 4; i++) begin
      #1 chk($sformatf("halt_c%0d", i), {11'd0, halted, act_ctl}, {12'd1, ctl(1,0,1,0,0,2'b00,2'b00)});
      @(negedge clk);
    end
    halt_D = 0; resume = 1;
    #1 chk("resume_cyc", {11'd0, halted, act_ctl}, {12'd1, ctl(0,0,1,0,0,2'b00,2'b00)});
    @(negedge clk);
    resume = 0;
    #1 chk("after_resume", {11'd0, halted, act_ctl}, 32'd0);
    halt_D = 1;
    @(negedge clk);
    halt_D = 0;
    #1 chk("halt_again", {31'd0, halted}, 32'd1);
    reset = 1;
    #1 chk("reset_in_halt", {11'd0, halted, act_ctl}, 32'd0);
    @(negedge clk);
    reset = 0;
    #1 chk("run_after_reset", {11'd0, halted, act_ctl}, 32'd0);
    $display("seq halt: halted=%0d", halted);

    // Stall counter saturates; clear wins over a simultaneous increment.
    do_reset();
    halt_D = 1;
    @(negedge clk);
    halt_D = 0;
    repeat ((1 << CW) + 5) @(negedge clk);
    #1 chk("sat_stall_cnt", {24'd0, stall_cnt}, 32'hFF);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    #1 chk("clr_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    #1 chk("inc_after_clr", {24'd0, stall_cnt}, 32'd1);
    $display("seq saturate: stall_cnt=%0d", stall_cnt);
    resume = 1;
    @(negedge clk);
    resume = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
